// File: rtl/inst_assembler.sv
// ---------------------------------------------------------------------------
// inst_assembler
//
// Streaming RV32I instruction encoder. Each accepted set of fields is packed
// into a 32-bit instruction word (immediate bits scattered per format) and
// presented on a single output register together with the instruction-memory
// address it should be written to. Words whose immediate is out of range or
// misaligned for the format, or whose format code is illegal, are replaced by
// a NOP (addi x0,x0,0) and flagged with out_err.
//
// Optional feature macro: OPCODE_CHECK_EN
//   When defined, the opcode must also be one that belongs to the requested
//   format, otherwise the word is flagged and replaced by a NOP.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   in_valid/ready  input handshake (in_ready = !out_valid || out_ready)
//   in_fmt          0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm
//                   instruction fields; in_imm is a signed byte offset
//   addr_load/in    reload of the target address counter
//   out_valid/ready output handshake
//   out_inst        encoded instruction word
//   out_addr        target address of out_inst
//   out_err         encoding failed, out_inst is the NOP
//   err_sticky      set by any emitted error word, cleared by rst/err_clear
//   err_clear       synchronous clear of err_sticky
//   emit_count      completed output handshakes, wraps at 16 bits
// ---------------------------------------------------------------------------
module inst_assembler #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              err_sticky,
  input  logic              err_clear,
  output logic [15:0]       emit_count
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmtT;

  logic              outValid_q, outValid_d;
  logic [31:0]       outInst_q, outInst_d;
  logic [ADDR_W-1:0] outAddr_q, outAddr_d;
  logic              outErr_q, outErr_d;
  logic              errSticky_q, errSticky_d;
  logic [15:0]       emitCount_q, emitCount_d;
  logic [ADDR_W-1:0] addrCnt_q, addrCnt_d;

  logic              accept;
  logic              handshake;
  logic [ADDR_W-1:0] wordAddr;

  logic              immFitsI;
  logic              immFitsB;
  logic              immFitsJ;
  logic [31:0]       rawInst;
  logic              fieldErr;
  logic              opcodeErr;
  logic              encErr;

  assign in_ready  = !outValid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign handshake = outValid_q && out_ready;

  // A load in the same cycle as an accept redirects that very word.
  assign wordAddr = addr_load ? addr_in : addrCnt_q;

  // Range checks expressed as sign-extension checks: the immediate fits an
  // N-bit signed field exactly when all bits above bit N-1 copy bit N-1.
  assign immFitsI = (in_imm[31:11] == {21{in_imm[11]}});
  assign immFitsB = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
  assign immFitsJ = (in_imm[31:20] == {12{in_imm[20]}}) && !in_imm[0];

  // Field packing per format, with the format-dependent immediate checks.
  always_comb begin
    rawInst  = NOP_INST;
    fieldErr = 1'b1;
    case (in_fmt)
      FMT_R: begin
        rawInst  = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        fieldErr = 1'b0;
      end
      FMT_I: begin
        rawInst  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        fieldErr = !immFitsI;
      end
      FMT_S: begin
        rawInst  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        fieldErr = !immFitsI;
      end
      FMT_B: begin
        rawInst  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        fieldErr = !immFitsB;
      end
      FMT_U: begin
        rawInst  = {in_imm[31:12], in_rd, in_opcode};
        fieldErr = (in_imm[11:0] != 12'd0);
      end
      FMT_J: begin
        rawInst  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        fieldErr = !immFitsJ;
      end
      default: begin
        rawInst  = NOP_INST;
        fieldErr = 1'b1;
      end
    endcase
  end

`ifdef OPCODE_CHECK_EN
  // Only opcodes that genuinely use the requested format are allowed.
  always_comb begin
    opcodeErr = 1'b1;
    case (in_fmt)
      FMT_R:   opcodeErr = (in_opcode != 7'b0110011);
      FMT_I:   opcodeErr = !((in_opcode == 7'b0010011) || (in_opcode == 7'b0000011) ||
                             (in_opcode == 7'b1100111));
      FMT_S:   opcodeErr = (in_opcode != 7'b0100011);
      FMT_B:   opcodeErr = (in_opcode != 7'b1100011);
      FMT_U:   opcodeErr = !((in_opcode == 7'b0110111) || (in_opcode == 7'b0010111));
      FMT_J:   opcodeErr = (in_opcode != 7'b1101111);
      default: opcodeErr = 1'b1;
    endcase
  end
`else
  assign opcodeErr = 1'b0;
`endif

  assign encErr = fieldErr || opcodeErr;

  // Next-state for the output register, address counter and status.
  // The output register only changes on accept, which keeps out_* stable
  // while the downstream is stalling.
  always_comb begin
    outValid_d  = outValid_q;
    outInst_d   = outInst_q;
    outAddr_d   = outAddr_q;
    outErr_d    = outErr_q;
    errSticky_d = errSticky_q;
    emitCount_d = emitCount_q;
    addrCnt_d   = addrCnt_q;

    if (accept) begin
      outValid_d = 1'b1;
      outInst_d  = encErr ? NOP_INST : rawInst;
      outErr_d   = encErr;
      outAddr_d  = wordAddr;
      addrCnt_d  = wordAddr + ADDR_W'(4);
    end else begin
      if (handshake) begin
        outValid_d = 1'b0;
      end
      if (addr_load) begin
        addrCnt_d = addr_in;
      end
    end

    if (handshake) begin
      emitCount_d = emitCount_q + 16'd1;
    end

    // Setting by an erroring handshake takes priority over err_clear.
    if (handshake && outErr_q) begin
      errSticky_d = 1'b1;
    end else if (err_clear) begin
      errSticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q  <= 1'b0;
      outInst_q   <= 32'd0;
      outAddr_q   <= BASE_ADDR;
      outErr_q    <= 1'b0;
      errSticky_q <= 1'b0;
      emitCount_q <= 16'd0;
      addrCnt_q   <= BASE_ADDR;
    end else begin
      outValid_q  <= outValid_d;
      outInst_q   <= outInst_d;
      outAddr_q   <= outAddr_d;
      outErr_q    <= outErr_d;
      errSticky_q <= errSticky_d;
      emitCount_q <= emitCount_d;
      addrCnt_q   <= addrCnt_d;
    end
  end

  assign out_valid  = outValid_q;
  assign out_inst   = outInst_q;
  assign out_addr   = outAddr_q;
  assign out_err    = outErr_q;
  assign err_sticky = errSticky_q;
  assign emit_count = emitCount_q;

endmodule

// File: tb/tb_inst_assembler.sv
// ---------------------------------------------------------------------------
// tb_inst_assembler
//
// Self-checking bench for inst_assembler. Inputs are driven on the falling
// edge and outputs sampled 1 ns later. Every accepted word pushes its
// expected encoding/address/error onto a queue; every output handshake pops
// and compares. Status outputs (emit_count, err_sticky) are tracked by a
// small model and compared every cycle; stalled outputs are checked for
// stability.
// ---------------------------------------------------------------------------
module tb_inst_assembler;

  localparam int          ADDR_W = 32;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } expT;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              addr_load;
  logic [ADDR_W-1:0] addr_in;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;
  logic              err_sticky;
  logic              err_clear;
  logic [15:0]       emit_count;

  int          checkCount = 0;
  int          failCount  = 0;
  expT         sb[$];
  logic [31:0] expCnt;
  logic [15:0] expEmit;
  logic        expSticky;
  logic        holdPending;
  logic [31:0] holdInst;
  logic [31:0] holdAddr;
  logic        holdErr;

  always #5 clk = ~clk;

  inst_assembler #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fmt     (in_fmt),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .addr_load  (addr_load),
    .addr_in    (addr_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .out_addr   (out_addr),
    .out_err    (out_err),
    .err_sticky (err_sticky),
    .err_clear  (err_clear),
    .emit_count (emit_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference encoder written bit by bit with integer range checks.
  function automatic logic [32:0] modelEncode(input logic [2:0] fmt, input logic [6:0] opc,
                                              input logic [4:0] rd, input logic [4:0] rs1,
                                              input logic [4:0] rs2, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic [31:0] imm);
    int          s;
    logic [31:0] w;
    logic        bad;
    s = $signed(imm);
    w = 32'd0;
    w[6:0] = opc;
    bad = 1'b0;
    case (fmt)
      3'd0: begin
        w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1; w[24:20] = rs2; w[31:25] = f7;
      end
      3'd1: begin
        w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1; w[31:20] = imm[11:0];
        bad = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        w[11:7] = imm[4:0]; w[14:12] = f3; w[19:15] = rs1; w[24:20] = rs2; w[31:25] = imm[11:5];
        bad = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        w[7] = imm[11]; w[11:8] = imm[4:1]; w[14:12] = f3; w[19:15] = rs1; w[24:20] = rs2;
        w[30:25] = imm[10:5]; w[31] = imm[12];
        bad = (s < -4096) || (s > 4094) || imm[0];
      end
      3'd4: begin
        w[11:7] = rd; w[31:12] = imm[31:12];
        bad = (imm[11:0] != 12'd0);
      end
      3'd5: begin
        w[11:7] = rd; w[19:12] = imm[19:12]; w[20] = imm[11]; w[30:21] = imm[10:1]; w[31] = imm[20];
        bad = (s < -1048576) || (s > 1048574) || imm[0];
      end
      default: bad = 1'b1;
    endcase
`ifdef OPCODE_CHECK_EN
    case (fmt)
      3'd0: if (opc != 7'h33) bad = 1'b1;
      3'd1: if (opc != 7'h13 && opc != 7'h03 && opc != 7'h67) bad = 1'b1;
      3'd2: if (opc != 7'h23) bad = 1'b1;
      3'd3: if (opc != 7'h63) bad = 1'b1;
      3'd4: if (opc != 7'h37 && opc != 7'h17) bad = 1'b1;
      3'd5: if (opc != 7'h6F) bad = 1'b1;
      default: bad = 1'b1;
    endcase
`endif
    return {bad, bad ? NOP : w};
  endfunction

  // One clock: sample, check, update the model, advance to the next falling edge.
  task automatic stepCycle(output bit acc);
    expT         e;
    logic [32:0] m;
    logic [31:0] a;
    logic        hs;
    logic        popErr;
    #1;
    checkOutput("emit_count", {16'd0, emit_count}, {16'd0, expEmit});
    checkOutput("err_sticky", {31'd0, err_sticky}, {31'd0, expSticky});
    if (holdPending) begin
      checkOutput("stall_inst", out_inst, holdInst);
      checkOutput("stall_addr", out_addr, holdAddr);
      checkOutput("stall_err", {31'd0, out_err}, {31'd0, holdErr});
    end
    holdPending = out_valid && !out_ready;
    holdInst = out_inst;
    holdAddr = out_addr;
    holdErr  = out_err;
    hs = out_valid && out_ready;
    popErr = 1'b0;
    if (hs) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_word", {31'd0, out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("word_inst", out_inst, e.inst);
        checkOutput("word_addr", out_addr, e.addr);
        checkOutput("word_err", {31'd0, out_err}, {31'd0, e.err});
        popErr = e.err;
      end
      expEmit = expEmit + 16'd1;
    end
    if (hs && popErr) expSticky = 1'b1;
    else if (err_clear) expSticky = 1'b0;
    acc = in_valid && in_ready;
    if (acc) begin
      a = addr_load ? addr_in : expCnt;
      m = modelEncode(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
      e.inst = m[31:0];
      e.err  = m[32];
      e.addr = a;
      sb.push_back(e);
      expCnt = a + 32'd4;
    end else if (addr_load) begin
      expCnt = addr_in;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one word and hold it until accepted (bounded).
  task automatic applyStimulus(input logic [2:0] fmt, input logic [6:0] opc, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] imm);
    bit acc;
    int budget;
    in_fmt = fmt; in_opcode = opc; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    in_valid = 1'b1;
    acc = 1'b0;
    budget = 0;
    while (!acc && budget < 20) begin
      if (budget == 2) out_ready = 1'b1;
      stepCycle(acc);
      budget++;
    end
    if (!acc) checkOutput("accept_timeout", {31'd0, acc}, 32'd1);
    in_valid  = 1'b0;
    addr_load = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) stepCycle(acc);
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    sb.delete();
    expCnt = 32'd0; expEmit = 16'd0; expSticky = 1'b0; holdPending = 1'b0;
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_inst", out_inst, 32'd0);
    checkOutput("rst_addr", out_addr, 32'd0);
    checkOutput("rst_err", {31'd0, out_err}, 32'd0);
    checkOutput("rst_sticky", {31'd0, err_sticky}, 32'd0);
    checkOutput("rst_emit", {16'd0, emit_count}, 32'd0);
    #3;
    rst = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0] immTable [16] = '{32'd0, 32'd4, -32'sd4, 32'd2047, 32'd2048, -32'sd2048, -32'sd2049,
                                 32'd4094, 32'd4095, -32'sd4096, -32'sd4098, 32'd1048574,
                                 -32'sd1048576, 32'd1048576, 32'h1234_5000, 32'h1234_5001};
  logic [6:0]  opcTable [8] = '{7'h33, 7'h13, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h03, 7'h17};

  initial begin
    bit acc;
    rst = 1'b1; in_valid = 1'b0; in_fmt = 3'd0; in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0;
    in_rs2 = 5'd0; in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'd0; addr_load = 1'b0;
    addr_in = 32'd0; out_ready = 1'b1; err_clear = 1'b0;
    @(negedge clk);
    doReset();

    // addi x1,x0,5 at address 0
    applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    #1 checkOutput("t1_inst", out_inst, 32'h0050_0093);
    checkOutput("t1_addr", out_addr, 32'd0);
    idleCycles(2);
    checkOutput("t1_emit", {16'd0, emit_count}, 32'd1);

    // beq x1,x2,-8 then jal x1,2048
    applyStimulus(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd8);
    #1 checkOutput("t2_binst", out_inst, 32'hFE20_8CE3);
    applyStimulus(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    #1 checkOutput("t2_jinst", out_inst, 32'h0010_00EF);
    checkOutput("t2_jaddr", out_addr, 32'd8);
    idleCycles(1);

    // error words, sticky flag, clear
    applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    applyStimulus(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    applyStimulus(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    #1 checkOutput("t3_nop", out_inst, NOP);
    checkOutput("t3_err", {31'd0, out_err}, 32'd1);
    idleCycles(2);
    checkOutput("t3_sticky", {31'd0, err_sticky}, 32'd1);
    err_clear = 1'b1;
    idleCycles(1);
    err_clear = 1'b0;
    idleCycles(1);
    // err_clear coincident with an erroring handshake keeps the flag set
    applyStimulus(3'd4, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001);
    err_clear = 1'b1;
    idleCycles(1);
    err_clear = 1'b0;
    idleCycles(1);
    err_clear = 1'b1;
    idleCycles(1);
    err_clear = 1'b0;

    // boundary values that must encode cleanly
    applyStimulus(3'd3, 7'h63, 5'd0, 5'd3, 5'd4, 3'd1, 7'd0, 32'd4094);
    applyStimulus(3'd2, 7'h23, 5'd0, 5'd5, 5'd6, 3'd2, 7'd0, -32'sd2048);
    applyStimulus(3'd5, 7'h6F, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd1048576);
    applyStimulus(3'd0, 7'h33, 5'd8, 5'd9, 5'd10, 3'd5, 7'h20, 32'hFFFF_FFFF);
    applyStimulus(3'd3, 7'h63, 5'd0, 5'd3, 5'd4, 3'd1, 7'd0, 32'd4096);
    idleCycles(2);

    // stall: two words with out_ready low for three cycles
    doReset();
    out_ready = 1'b0;
    in_fmt = 3'd1; in_opcode = 7'h13; in_rd = 5'd2; in_rs1 = 5'd1; in_funct3 = 3'd0;
    in_imm = 32'd100; in_valid = 1'b1;
    stepCycle(acc);
    checkOutput("t4_first_acc", {31'd0, acc}, 32'd1);
    in_imm = 32'd200; in_rd = 5'd3;
    #1 checkOutput("t4_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) stepCycle(acc);
    out_ready = 1'b1;
    applyStimulus(3'd1, 7'h13, 5'd3, 5'd1, 5'd0, 3'd0, 7'd0, 32'd200);
    #1 checkOutput("t4_second_addr", out_addr, 32'd4);
    idleCycles(2);

    // address load, coincident with accept and on its own
    addr_load = 1'b1; addr_in = 32'h100;
    applyStimulus(3'd4, 7'h17, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000);
    #1 checkOutput("t5_addr", out_addr, 32'h100);
    applyStimulus(3'd1, 7'h03, 5'd5, 5'd6, 5'd0, 3'd2, 7'd0, -32'sd12);
    #1 checkOutput("t5_next_addr", out_addr, 32'h104);
    addr_load = 1'b1; addr_in = 32'hFFFF_FFFC;
    idleCycles(1);
    addr_load = 1'b0;
    applyStimulus(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    applyStimulus(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    #1 checkOutput("t5_wrap_addr", out_addr, 32'd0);
    idleCycles(1);

`ifdef OPCODE_CHECK_EN
    applyStimulus(3'd2, 7'h13, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4);
    #1 checkOutput("t6_opc_err", {31'd0, out_err}, 32'd1);
    idleCycles(1);
`endif

    // randomized words with random back-pressure
    for (int i = 0; i < 40; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      applyStimulus(3'($urandom_range(0, 7)), opcTable[$urandom_range(0, 7)],
                    5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
                    ($urandom_range(0, 3) == 0) ? $urandom : immTable[$urandom_range(0, 15)]);
    end
    out_ready = 1'b1;
    idleCycles(2);

    // reset while a word is stalled on the output
    out_ready = 1'b0;
    applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    idleCycles(1);
    doReset();
    out_ready = 1'b1;
    applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    #1 checkOutput("t6_addr", out_addr, 32'd0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) idleCycles(1);
    checkOutput("drain_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/inst_assembler.md
Name: inst_assembler

Overview:
Streaming RISC-V RV32I instruction encoder, the inverse of the core's immediate decode path.
- Takes format class, opcode, register/function fields and a full 32-bit signed immediate.
- Packs the immediate into the correct scattered bit positions and emits the 32-bit instruction word tagged with its target instruction-memory address.
- Sits between the debug/boot loader front end and the instruction-memory write port.
- Checks immediate range and alignment per format.

Parameters:
BASE_ADDR, 32'h0000_0000, address counter value after reset
ADDR_W, 32, width of address counter and out_addr

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  input fields valid
in_ready  output  1  block can accept input this cycle
in_fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal
in_opcode  input  7  opcode field, placed in inst[6:0]
in_rd  input  5  rd, used for R/I/U/J
in_rs1  input  5  rs1, used for R/I/S/B
in_rs2  input  5  rs2, used for R/S/B
in_funct3  input  3  used for R/I/S/B
in_funct7  input  7  used for R only
in_imm  input  32  signed byte-offset immediate (U: full value, low 12 bits must be 0)
addr_load  input  1  load address counter from addr_in
addr_in  input  ADDR_W  new address value
out_valid  output  1  out_inst/out_addr/out_err valid
out_ready  input  1  downstream accepts output
out_inst  output  32  encoded instruction word
out_addr  output  ADDR_W  target address of out_inst
out_err  output  1  this word failed encoding; out_inst forced to NOP 32'h0000_0013
err_sticky  output  1  set on any emitted out_err=1; cleared only by rst or err_clear
err_clear  input  1  synchronous clear of err_sticky
emit_count  output  16  number of completed output handshakes, wraps at 16'hFFFF to 0

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_inst=0, out_addr=BASE_ADDR, out_err=0.
  - err_sticky=0, emit_count=0, address counter=BASE_ADDR.
  - A pending, unconsumed word is discarded.
- Pipeline: single output register.
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready. An accepted word appears on out_* the next cycle (latency 1).
  - Back-to-back throughput is 1 word/cycle while out_ready=1.
- Output stability: while out_valid=1 and out_ready=0, all out_* remain stable.
- Output handshake: out_valid && out_ready. Then emit_count increments; err_sticky sets if out_err=1.
- Address counter:
  - On accept, out_addr is captured from the counter and the counter advances by 4.
  - addr_load with no accept: counter = addr_in.
  - addr_load coincident with accept: the accepted word gets out_addr=addr_in and the counter becomes addr_in+4.
  - Counter wraps modulo 2^ADDR_W.
- Encoding, inst[6:0]=in_opcode in all cases:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Error checks, all evaluated at accept:
  - I/S: imm within [-2048, 2047].
  - B: imm within [-4096, 4094] and imm[0]=0.
  - J: imm within [-1048576, 1048574] and imm[0]=0.
  - U: imm[11:0]=0.
  - R: imm ignored.
  - fmt 6/7: always error.
  - On error: out_err=1, out_inst=32'h0000_0013. The address still advances; the word still consumes a slot.
- err_clear coincident with an erroring handshake: set wins, err_sticky=1.

Optional Feature:
OPCODE_CHECK_EN:
- Defined: at accept, in_opcode must belong to in_fmt, otherwise out_err=1 with the NOP substitution.
  - R: 0110011.
  - I: 0010011, 0000011, 1100111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
- Undefined: the opcode is passed through unchecked; only the immediate/fmt checks apply.

Test Plan:
1. After rst: I-type, opcode 0010011, rd=1, rs1=0, funct3=0, imm=5, out_ready=1 -> next cycle out_inst=32'h0050_0093, out_addr=0, out_err=0, emit_count=1.
2. B-type, opcode 1100011, rs1=1, rs2=2, funct3=0, imm=-8 -> out_inst=32'hFE20_8CE3. J-type, opcode 1101111, rd=1, imm=2048 -> out_inst=32'h0010_00EF, out_addr advances by 4.
3. I-type imm=2048, then B-type imm=3, then fmt=7 -> each gives out_err=1 and out_inst=32'h0000_0013; err_sticky=1 until err_clear.
4. Two inputs with out_ready=0 for 3 cycles -> in_ready=0 after the first accept; out_* stable; on release both words emitted in order with addresses 0 and 4.
5. addr_load=1, addr_in=32'h100, coincident with accept -> that word gets out_addr=32'h100; the next gets 32'h104.
6. rst asserted mid-cycle while out_valid=1 -> out_valid=0 immediately; emit_count=0; next word has out_addr=BASE_ADDR. With OPCODE_CHECK_EN: fmt=S, opcode 0010011 -> out_err=1.
